// File: rtl/cnn_pkg.sv
// Shared encodings for the CNN layer scheduler: FSM states, bank selects and
// default activation-bank geometry.
package cnn_pkg;

  localparam int unsigned CNN_ADDR_W = 10;
  localparam int unsigned CNN_DATA_W = 8;

  localparam int unsigned ST_W = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  // Layer i reads bank (i % 2); bank A also holds the input image.
  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  function automatic logic st_is_busy(input logic [ST_W-1:0] st);
    return (st == ST_START) || (st == ST_WAIT) || (st == ST_NEXT);
  endfunction

endpackage

// File: rtl/act_bank_mux.sv
// Routes the two single-port activation banks either to the active layer engine
// (read bank / write bank pair) or to the host when the scheduler is idle.
module act_bank_mux
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned ADDR_W     = CNN_ADDR_W,
  parameter int unsigned DATA_W     = CNN_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_busy,
  input  logic                         i_rd_bank,
  input  logic [NUM_LAYERS-1:0]        i_sel,
  input  logic [NUM_LAYERS*ADDR_W-1:0] i_rd_addr,
  input  logic [NUM_LAYERS*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_LAYERS*DATA_W-1:0] i_wr_data,
  input  logic [NUM_LAYERS-1:0]        i_wr_en,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic [ADDR_W-1:0]            o_a_addr,
  output logic                         o_a_we,
  output logic [DATA_W-1:0]            o_a_wdata,
  input  logic [DATA_W-1:0]            i_a_rdata,
  output logic [ADDR_W-1:0]            o_b_addr,
  output logic                         o_b_we,
  output logic [DATA_W-1:0]            o_b_wdata,
  input  logic [DATA_W-1:0]            i_b_rdata,
  input  logic [ADDR_W-1:0]            i_host_addr,
  input  logic                         i_host_bank,
  input  logic                         i_host_we,
  input  logic [DATA_W-1:0]            i_host_wdata,
  output logic [DATA_W-1:0]            o_host_rdata
);

  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_wr_en;
  logic              r_rd_bank;
  logic              r_host_bank;

  // One-hot select of the active engine's ports.
  always_comb begin
    w_rd_addr = '0;
    w_wr_addr = '0;
    w_wr_data = '0;
    w_wr_en   = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (i_sel[i]) begin
        w_rd_addr = w_rd_addr | i_rd_addr[i*ADDR_W +: ADDR_W];
        w_wr_addr = w_wr_addr | i_wr_addr[i*ADDR_W +: ADDR_W];
        w_wr_data = w_wr_data | i_wr_data[i*DATA_W +: DATA_W];
        w_wr_en   = w_wr_en   | i_wr_en[i];
      end
    end
  end

  always_comb begin
    o_a_addr  = '0;
    o_a_we    = 1'b0;
    o_a_wdata = '0;
    o_b_addr  = '0;
    o_b_we    = 1'b0;
    o_b_wdata = '0;
    if (i_busy) begin
      if (i_rd_bank == BANK_A) begin
        o_a_addr  = w_rd_addr;
        o_b_addr  = w_wr_addr;
        o_b_we    = w_wr_en;
        o_b_wdata = w_wr_data;
      end else begin
        o_b_addr  = w_rd_addr;
        o_a_addr  = w_wr_addr;
        o_a_we    = w_wr_en;
        o_a_wdata = w_wr_data;
      end
    end else if (i_host_bank == BANK_A) begin
      o_a_addr  = i_host_addr;
      o_a_we    = i_host_we;
      o_a_wdata = i_host_wdata;
    end else begin
      o_b_addr  = i_host_addr;
      o_b_we    = i_host_we;
      o_b_wdata = i_host_wdata;
    end
  end

  // Bank selects follow the address by one cycle to line up with rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_bank   <= BANK_A;
      r_host_bank <= BANK_A;
    end else begin
      r_rd_bank   <= i_rd_bank;
      r_host_bank <= i_host_bank;
    end
  end

  assign o_rd_data    = (r_rd_bank == BANK_B) ? i_b_rdata : i_a_rdata;
  assign o_host_rdata = i_busy ? '0 : ((r_host_bank == BANK_B) ? i_b_rdata : i_a_rdata);

endmodule

// File: rtl/cnn_layer_scheduler.sv
// Sequences the CNN layer engines for one inference: start pulse, done-edge wait
// with timeout, then next layer; activation banks are shared via act_bank_mux.
module cnn_layer_scheduler
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = 4,
  parameter int unsigned ADDR_W      = CNN_ADDR_W,
  parameter int unsigned DATA_W      = CNN_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         img_start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(NUM_LAYERS):0]  layer_idx,
  output logic                         result_bank,
  output logic [NUM_LAYERS-1:0]        layer_start,
  input  logic [NUM_LAYERS-1:0]        layer_done,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_rd_addr,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_wr_addr,
  input  logic [NUM_LAYERS*DATA_W-1:0] layer_wr_data,
  input  logic [NUM_LAYERS-1:0]        layer_wr_en,
  output logic [DATA_W-1:0]            layer_rd_data,
  output logic [ADDR_W-1:0]            a_addr,
  output logic                         a_we,
  output logic [DATA_W-1:0]            a_wdata,
  input  logic [DATA_W-1:0]            a_rdata,
  output logic [ADDR_W-1:0]            b_addr,
  output logic                         b_we,
  output logic [DATA_W-1:0]            b_wdata,
  input  logic [DATA_W-1:0]            b_rdata,
  input  logic [ADDR_W-1:0]            host_addr,
  input  logic                         host_bank,
  input  logic                         host_we,
  input  logic [DATA_W-1:0]            host_wdata,
  output logic [DATA_W-1:0]            host_rdata
);

  localparam int unsigned IDX_W    = $clog2(NUM_LAYERS) + 1;
  localparam int unsigned TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned TMR_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int unsigned LAST_IDX = NUM_LAYERS - 1;

  logic [ST_W-1:0]       r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [TMR_W-1:0]      r_timer;
  logic [NUM_LAYERS-1:0] r_done_q;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [NUM_LAYERS-1:0] r_layer_start;

  logic [ST_W-1:0]       w_state_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [TMR_W-1:0]      w_timer_nxt;
  logic                  w_error_nxt;
  logic [NUM_LAYERS-1:0] w_start_nxt;
  logic [NUM_LAYERS-1:0] w_sel;
  logic                  w_done_edge;
  logic                  w_timeout;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_sel[i] = (r_idx == IDX_W'(i));
    end
  end

  // Only a fresh 0->1 edge on the active engine's done counts; held levels do not.
  assign w_done_edge = |(layer_done & ~r_done_q & w_sel);
  assign w_timeout   = (TIMEOUT_CYC != 0) && (r_timer == TMR_W'(TMR_LAST));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_timer_nxt = r_timer;
    w_error_nxt = r_error;
    w_start_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (img_start) begin
          w_state_nxt = ST_START;
          w_idx_nxt   = '0;
          w_error_nxt = 1'b0;
        end
      end
      ST_START: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_done_edge) begin
          w_state_nxt = (r_idx == IDX_W'(LAST_IDX)) ? ST_DONE : ST_NEXT;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERR;
          w_error_nxt = 1'b1;
        end else if (TIMEOUT_CYC != 0) begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      ST_NEXT: begin
        w_idx_nxt   = r_idx + IDX_W'(1);
        w_state_nxt = ST_START;
      end
      ST_DONE, ST_ERR: begin
        if (img_start) begin
          w_state_nxt = ST_START;
          w_idx_nxt   = '0;
          w_error_nxt = 1'b0;
        end else if (r_state == ST_DONE) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    // Abort overrides every other request; engines are left untouched.
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_timer_nxt = '0;
    end

    if (w_state_nxt == ST_START) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        w_start_nxt[i] = (w_idx_nxt == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_timer       <= '0;
      r_done_q      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_layer_start <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_timer       <= w_timer_nxt;
      r_done_q      <= layer_done;
      r_busy        <= st_is_busy(w_state_nxt);
      r_done        <= (w_state_nxt == ST_DONE);
      r_error       <= w_error_nxt;
      r_layer_start <= w_start_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign layer_idx   = r_idx;
  assign layer_start = r_layer_start;
  assign result_bank = 1'(NUM_LAYERS % 2);

  act_bank_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) u_bank_mux (
    .clk          (clk),
    .rst          (rst),
    .i_busy       (r_busy),
    .i_rd_bank    (r_idx[0]),
    .i_sel        (w_sel),
    .i_rd_addr    (layer_rd_addr),
    .i_wr_addr    (layer_wr_addr),
    .i_wr_data    (layer_wr_data),
    .i_wr_en      (layer_wr_en),
    .o_rd_data    (layer_rd_data),
    .o_a_addr     (a_addr),
    .o_a_we       (a_we),
    .o_a_wdata    (a_wdata),
    .i_a_rdata    (a_rdata),
    .o_b_addr     (b_addr),
    .o_b_we       (b_we),
    .o_b_wdata    (b_wdata),
    .i_b_rdata    (b_rdata),
    .i_host_addr  (host_addr),
    .i_host_bank  (host_bank),
    .i_host_we    (host_we),
    .i_host_wdata (host_wdata),
    .o_host_rdata (host_rdata)
  );

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Directed bench for cnn_layer_scheduler: stub engines finishing 20 cycles after
// start, behavioural 1-cycle-latency banks, timeout, abort and level-done cases.
module tb_cnn_layer_scheduler;

  localparam int unsigned NL  = 4;
  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 50;

  logic              clk = 1'b0;
  logic              rst;
  logic              img_start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              error;
  logic [2:0]        layer_idx;
  logic              result_bank;
  logic [NL-1:0]     layer_start;
  logic [NL-1:0]     layer_done;
  logic [NL*AW-1:0]  layer_rd_addr;
  logic [NL*AW-1:0]  layer_wr_addr;
  logic [NL*DW-1:0]  layer_wr_data;
  logic [NL-1:0]     layer_wr_en;
  logic [DW-1:0]     layer_rd_data;
  logic [AW-1:0]     a_addr;
  logic              a_we;
  logic [DW-1:0]     a_wdata;
  logic [DW-1:0]     a_rdata;
  logic [AW-1:0]     b_addr;
  logic              b_we;
  logic [DW-1:0]     b_wdata;
  logic [DW-1:0]     b_rdata;
  logic [AW-1:0]     host_addr;
  logic              host_bank;
  logic              host_we;
  logic [DW-1:0]     host_wdata;
  logic [DW-1:0]     host_rdata;

  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0;
  int seen;
  int t_start [NL];

  always #5 clk = ~clk;

  cnn_layer_scheduler #(
    .NUM_LAYERS  (NL),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .img_start     (img_start),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .layer_idx     (layer_idx),
    .result_bank   (result_bank),
    .layer_start   (layer_start),
    .layer_done    (layer_done),
    .layer_rd_addr (layer_rd_addr),
    .layer_wr_addr (layer_wr_addr),
    .layer_wr_data (layer_wr_data),
    .layer_wr_en   (layer_wr_en),
    .layer_rd_data (layer_rd_data),
    .a_addr        (a_addr),
    .a_we          (a_we),
    .a_wdata       (a_wdata),
    .a_rdata       (a_rdata),
    .b_addr        (b_addr),
    .b_we          (b_we),
    .b_wdata       (b_wdata),
    .b_rdata       (b_rdata),
    .host_addr     (host_addr),
    .host_bank     (host_bank),
    .host_we       (host_we),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata)
  );

  // Single-port banks with synchronous read.
  always @(posedge clk) begin
    if (a_we) mem_a[a_addr] <= a_wdata;
    a_rdata <= mem_a[a_addr];
    if (b_we) mem_b[b_addr] <= b_wdata;
    b_rdata <= mem_b[b_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_start(input int i);
    int n;
    n = 0;
    while (layer_start == '0 && n < 10) begin
      step(1);
      n++;
    end
    t_start[i] = cyc;
    check_eq($sformatf("start_onehot_%0d", i), 32'(layer_start), 32'(1) << i);
    check_eq($sformatf("start_idx_%0d", i), 32'(layer_idx), 32'(i));
  endtask

  // Stub engine: done pulse 20 cycles after start, plus a few bank accesses.
  task automatic run_layer(input int i);
    wait_start(i);
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (c == 1) check_eq($sformatf("start_single_%0d", i), 32'(layer_start), 32'(0));
      if (i == 0 && c == 3) begin
        host_bank  = 1'b0;
        host_addr  = AW'(3);
        host_wdata = 8'hEE;
        host_we    = 1'b1;
      end
      if (i == 0 && c == 4) begin
        host_we = 1'b0;
        check_eq("host_rdata_busy", 32'(host_rdata), 32'(0));
      end
      if (i == 1 && c == 3) begin
        layer_wr_addr[1*AW +: AW] = AW'(7);
        layer_wr_data[1*DW +: DW] = 8'h5A;
        layer_wr_en               = 4'b0010;
      end
      if (i == 1 && c == 4) layer_wr_en = 4'b0000;
      if (i == 2 && c == 3) layer_rd_addr[2*AW +: AW] = AW'(7);
      if (i == 2 && c == 4) check_eq("engine2_rd_7", 32'(layer_rd_data), 32'h5A);
    end
    layer_done = layer_done | (4'(1) << i);
    step(1);
    layer_done = layer_done & ~(4'(1) << i);
  endtask

  initial begin
    rst           = 1'b1;
    img_start     = 1'b0;
    abort         = 1'b0;
    layer_done    = '0;
    layer_rd_addr = '0;
    layer_wr_addr = '0;
    layer_wr_data = '0;
    layer_wr_en   = '0;
    host_addr     = '0;
    host_bank     = 1'b0;
    host_we       = 1'b0;
    host_wdata    = '0;
    step(2);
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_done", 32'(done), 32'(0));
    check_eq("rst_error", 32'(error), 32'(0));
    check_eq("rst_idx", 32'(layer_idx), 32'(0));
    check_eq("rst_start", 32'(layer_start), 32'(0));
    check_eq("rst_a_we", 32'(a_we), 32'(0));
    check_eq("rst_b_we", 32'(b_we), 32'(0));
    check_eq("result_bank", 32'(result_bank), 32'(0));
    rst = 1'b0;
    step(1);

    // Host writes A[3]=0x11 and B[3]=0x22, then reads both back-to-back.
    host_bank = 1'b0; host_addr = AW'(3); host_wdata = 8'h11; host_we = 1'b1;
    step(1);
    host_bank = 1'b1; host_wdata = 8'h22;
    step(1);
    host_we = 1'b0; host_bank = 1'b0;
    step(1);
    check_eq("host_rd_a3", 32'(host_rdata), 32'h11);
    host_bank = 1'b1;
    step(1);
    check_eq("host_rd_b3", 32'(host_rdata), 32'h22);

    // Full inference with stub engines.
    img_start = 1'b1;
    t0 = cyc;
    step(1);
    img_start = 1'b0;
    for (int i = 0; i < NL; i++) run_layer(i);
    check_eq("lat_img_to_start0", 32'(t_start[0] - t0), 32'(1));
    for (int i = 1; i < NL; i++)
      check_eq($sformatf("lat_start_%0d", i), 32'(t_start[i] - t_start[i-1]), 32'(22));
    check_eq("done_pulse", 32'(done), 32'(1));
    check_eq("total_cycles", 32'(cyc - t0), 32'(88));
    step(1);
    check_eq("done_one_cycle", 32'(done), 32'(0));
    check_eq("idle_after_done", 32'(busy), 32'(0));
    check_eq("bank_a_7", 32'(mem_a[7]), 32'h5A);
    check_eq("bank_a_3_kept", 32'(mem_a[3]), 32'h11);

    // Engine 2 never finishes: timeout into ERR with the index frozen.
    img_start = 1'b1;
    step(1);
    img_start = 1'b0;
    run_layer(0);
    run_layer(1);
    wait_start(2);
    step(50);
    check_eq("tmo_not_yet", 32'(error), 32'(0));
    step(1);
    check_eq("tmo_error", 32'(error), 32'(1));
    check_eq("tmo_not_busy", 32'(busy), 32'(0));
    check_eq("tmo_idx", 32'(layer_idx), 32'(2));
    step(5);
    check_eq("err_sticky", 32'(error), 32'(1));
    check_eq("err_idx_frozen", 32'(layer_idx), 32'(2));
    img_start = 1'b1;
    step(1);
    img_start = 1'b0;
    check_eq("restart_start", 32'(layer_start), 32'(1));
    check_eq("restart_error", 32'(error), 32'(0));

    // Abort in WAIT of layer 1, together with its done.
    run_layer(0);
    wait_start(1);
    step(10);
    abort = 1'b1;
    layer_done = 4'b0010;
    step(1);
    abort = 1'b0;
    layer_done = 4'b0000;
    check_eq("abort_busy", 32'(busy), 32'(0));
    check_eq("abort_idx", 32'(layer_idx), 32'(0));
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (layer_start != '0 || done) seen++;
    end
    check_eq("abort_quiet", 32'(seen), 32'(0));

    // Done held high from before: no advance until a fresh rising edge.
    layer_done = 4'b0001;
    step(1);
    img_start = 1'b1;
    step(1);
    img_start = 1'b0;
    check_eq("level_start0", 32'(layer_start), 32'(1));
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (layer_start != '0) seen++;
    end
    check_eq("level_no_advance", 32'(seen), 32'(0));
    check_eq("level_idx", 32'(layer_idx), 32'(0));
    check_eq("level_busy", 32'(busy), 32'(1));
    layer_done = 4'b0000;
    step(1);
    layer_done = 4'b0001;
    step(1);
    layer_done = 4'b0000;
    step(1);
    check_eq("level_edge_start1", 32'(layer_start), 32'b0010);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by time limit, expected finish");
    $fatal(1);
  end

endmodule
